// File: rtl/conv_seq_ctrl.sv
// Batch sequencer for the conv1 core: streams NPIX pixels per image into the core,
// forwards NOUT results per image to the sink, and reports done/busy/sticky errors.
module conv_seq_ctrl #(
    parameter int DW      = 16,
    parameter int RW      = 32,
    parameter int IMG_H   = 28,
    parameter int IMG_W   = 28,
    parameter int K       = 3,
    parameter int TIMEOUT = 4096
) (
    input  logic          clk,
    input  logic          resetn,
    input  logic          start,
    input  logic [7:0]    num_img,
    input  logic          src_valid,
    output logic          src_ready,
    input  logic [DW-1:0] src_data,
    output logic [DW-1:0] core_data_in,
    output logic          core_rdata_r,
    output logic          core_clr,
    input  logic [RW-1:0] core_data_out,
    input  logic          core_wdata_r,
    output logic          snk_valid,
    output logic [RW-1:0] snk_data,
    output logic          snk_last,
    output logic [7:0]    img_idx,
    output logic          busy,
    output logic          done,
    output logic          err_timeout,
    output logic          err_extra,
    output logic [2:0]    dbg_state
);
    localparam int NPIX = IMG_H * IMG_W;
    localparam int NOUT = (IMG_H - K + 1) * (IMG_W - K + 1);
    localparam int PW   = $clog2(NPIX + 1);
    localparam int OW   = $clog2(NOUT + 1);
    localparam int TW   = $clog2(TIMEOUT + 1);
    localparam logic [PW-1:0] NPIX_V    = PW'(NPIX);
    localparam logic [PW-1:0] NPIX_M1   = PW'(NPIX - 1);
    localparam logic [OW-1:0] NOUT_V    = OW'(NOUT);
    localparam logic [OW-1:0] NOUT_M1   = OW'(NOUT - 1);
    localparam logic [TW-1:0] TIMEOUT_V = TW'(TIMEOUT);

    typedef enum logic [2:0] {S_IDLE, S_CLR, S_LOAD, S_DRAIN, S_NEXT} state_t;

    state_t        state_q, state_d;
    logic [7:0]    num_img_q, num_img_d;
    logic [7:0]    img_idx_q, img_idx_d;
    logic [PW-1:0] pix_cnt_q, pix_cnt_d;
    logic [OW-1:0] out_cnt_q, out_cnt_d;
    logic [TW-1:0] idle_cnt_q, idle_cnt_d;
    logic [DW-1:0] core_data_in_q, core_data_in_d;
    logic          core_rdata_r_q, core_rdata_r_d;
    logic          snk_valid_q, snk_valid_d;
    logic [RW-1:0] snk_data_q, snk_data_d;
    logic          snk_last_q, snk_last_d;
    logic          done_q, done_d;
    logic          err_timeout_q, err_timeout_d;
    logic          err_extra_q, err_extra_d;
    logic          src_xfer;
    logic          res_accept;

    // Source handshake: a pixel moves on any cycle with src_valid && src_ready;
    // src_ready depends only on registered state, never on src_valid.
    assign src_ready  = (state_q == S_LOAD) && (pix_cnt_q < NPIX_V);
    assign src_xfer   = src_valid && src_ready;
    assign res_accept = core_wdata_r && (out_cnt_q < NOUT_V) &&
                        ((state_q == S_LOAD) || (state_q == S_DRAIN));

    always_comb begin
        state_d        = state_q;
        num_img_d      = num_img_q;
        img_idx_d      = img_idx_q;
        pix_cnt_d      = pix_cnt_q;
        out_cnt_d      = out_cnt_q;
        idle_cnt_d     = idle_cnt_q;
        core_data_in_d = core_data_in_q;
        core_rdata_r_d = 1'b0;
        snk_valid_d    = 1'b0;
        snk_data_d     = snk_data_q;
        snk_last_d     = 1'b0;
        done_d         = 1'b0;
        err_timeout_d  = err_timeout_q;
        err_extra_d    = err_extra_q;

        if (src_xfer) begin
            core_data_in_d = src_data;
            core_rdata_r_d = 1'b1;
            pix_cnt_d      = pix_cnt_q + 1'b1;
        end

        if (res_accept) begin
            snk_valid_d = 1'b1;
            snk_data_d  = core_data_out;
            snk_last_d  = (out_cnt_q == NOUT_M1);
            out_cnt_d   = out_cnt_q + 1'b1;
        end else if (core_wdata_r) begin
            err_extra_d = 1'b1;
        end
        // All results arrived before the image finished loading: the core is out of step.
        if ((state_q == S_LOAD) && (out_cnt_q == NOUT_V)) begin
            err_extra_d = 1'b1;
        end

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    num_img_d     = num_img;
                    err_timeout_d = 1'b0;
                    err_extra_d   = core_wdata_r;
                    if (num_img == 8'd0) begin
                        done_d = 1'b1;
                    end else begin
                        img_idx_d = 8'd0;
                        state_d   = S_CLR;
                    end
                end
            end
            S_CLR: begin
                pix_cnt_d  = '0;
                out_cnt_d  = '0;
                idle_cnt_d = '0;
                state_d    = S_LOAD;
            end
            S_LOAD: begin
                idle_cnt_d = '0;
                if (src_xfer && (pix_cnt_q == NPIX_M1)) begin
                    state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (out_cnt_q == NOUT_V) begin
                    state_d = S_NEXT;
                end else begin
                    idle_cnt_d = core_wdata_r ? '0 : idle_cnt_q + 1'b1;
                    if (idle_cnt_d == TIMEOUT_V) begin
                        err_timeout_d = 1'b1;
                        done_d        = 1'b1;
                        state_d       = S_IDLE;
                    end
                end
            end
            S_NEXT: begin
                if (img_idx_q == num_img_q - 8'd1) begin
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    img_idx_d = img_idx_q + 8'd1;
                    state_d   = S_CLR;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q        <= S_IDLE;
            num_img_q      <= '0;
            img_idx_q      <= '0;
            pix_cnt_q      <= '0;
            out_cnt_q      <= '0;
            idle_cnt_q     <= '0;
            core_data_in_q <= '0;
            core_rdata_r_q <= 1'b0;
            snk_valid_q    <= 1'b0;
            snk_data_q     <= '0;
            snk_last_q     <= 1'b0;
            done_q         <= 1'b0;
            err_timeout_q  <= 1'b0;
            err_extra_q    <= 1'b0;
        end else begin
            state_q        <= state_d;
            num_img_q      <= num_img_d;
            img_idx_q      <= img_idx_d;
            pix_cnt_q      <= pix_cnt_d;
            out_cnt_q      <= out_cnt_d;
            idle_cnt_q     <= idle_cnt_d;
            core_data_in_q <= core_data_in_d;
            core_rdata_r_q <= core_rdata_r_d;
            snk_valid_q    <= snk_valid_d;
            snk_data_q     <= snk_data_d;
            snk_last_q     <= snk_last_d;
            done_q         <= done_d;
            err_timeout_q  <= err_timeout_d;
            err_extra_q    <= err_extra_d;
        end
    end

    assign core_data_in = core_data_in_q;
    assign core_rdata_r = core_rdata_r_q;
    assign core_clr     = (state_q == S_CLR);
    assign snk_valid    = snk_valid_q;
    assign snk_data     = snk_data_q;
    assign snk_last     = snk_last_q;
    assign img_idx      = img_idx_q;
    assign busy         = (state_q != S_IDLE);
    assign done         = done_q;
    assign err_timeout  = err_timeout_q;
    assign err_extra    = err_extra_q;
    assign dbg_state    = state_q;
endmodule

// File: tb/tb_conv_seq_ctrl.sv
// Bench for conv_seq_ctrl: random pixel source, behavioural 3x3 all-ones conv core,
// and a scoreboard of window sums computed directly from the generated images.
module tb_conv_seq_ctrl;
    localparam int DW      = 16;
    localparam int RW      = 32;
    localparam int IMG_H   = 28;
    localparam int IMG_W   = 28;
    localparam int K       = 3;
    localparam int TIMEOUT = 64;
    localparam int NPIX    = IMG_H * IMG_W;
    localparam int OH      = IMG_H - K + 1;
    localparam int OWD     = IMG_W - K + 1;
    localparam int NOUT    = OH * OWD;

    logic          clk = 1'b0;
    logic          resetn = 1'b0;
    logic          start = 1'b0;
    logic [7:0]    num_img = '0;
    logic          src_valid = 1'b0;
    logic          src_ready;
    logic [DW-1:0] src_data = '0;
    logic [DW-1:0] core_data_in;
    logic          core_rdata_r;
    logic          core_clr;
    logic [RW-1:0] core_data_out = '0;
    logic          core_wdata_r = 1'b0;
    logic          snk_valid;
    logic [RW-1:0] snk_data;
    logic          snk_last;
    logic [7:0]    img_idx;
    logic          busy;
    logic          done;
    logic          err_timeout;
    logic          err_extra;
    logic [2:0]    dbg_state;

    conv_seq_ctrl #(.DW(DW), .RW(RW), .IMG_H(IMG_H), .IMG_W(IMG_W), .K(K), .TIMEOUT(TIMEOUT)) dut (
        .clk(clk), .resetn(resetn), .start(start), .num_img(num_img),
        .src_valid(src_valid), .src_ready(src_ready), .src_data(src_data),
        .core_data_in(core_data_in), .core_rdata_r(core_rdata_r), .core_clr(core_clr),
        .core_data_out(core_data_out), .core_wdata_r(core_wdata_r),
        .snk_valid(snk_valid), .snk_data(snk_data), .snk_last(snk_last),
        .img_idx(img_idx), .busy(busy), .done(done),
        .err_timeout(err_timeout), .err_extra(err_extra), .dbg_state(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
        $fatal(1, "watchdog");
    end

    // ---------------- shared state ----------------
    int n_checks = 0;
    int n_pass   = 0;

    logic [DW-1:0] src_q[$];
    logic [RW-1:0] exp_q[$];
    int            clr_idx_q[$];

    int valid_pct  = 100;
    int core_limit = NOUT;
    bit emit_extra = 1'b0;
    bit force_wd   = 1'b0;

    logic [DW-1:0] pbuf[NPIX];
    int            pcnt = 0;
    int            core_emit = 0;
    bit            pend = 1'b0;
    bit            extra_pend = 1'b0;
    logic [RW-1:0] pend_val = '0;

    int cyc = 0;
    int n_rd, n_clr, n_snk, n_last, n_done, n_xfer, rd_since_clr, busy_seen, sb_idx;
    int start_cyc, done_cyc, last_rd_cyc;
    logic [RW-1:0] first_snk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_checks++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, want);
    endtask

    task automatic clear_counters();
        n_rd = 0; n_clr = 0; n_snk = 0; n_last = 0; n_done = 0; n_xfer = 0;
        rd_since_clr = 0; busy_seen = 0; sb_idx = 0;
        start_cyc = -1000; done_cyc = -2000; last_rd_cyc = -3000;
        first_snk = '0;
        clr_idx_q.delete();
    endtask

    // Builds one image, queues its pixels, and queues the first 'limit' window sums.
    task automatic load_image(input bit ramp, input int limit);
        logic [DW-1:0] pix[NPIX];
        int s;
        for (int p = 0; p < NPIX; p++) begin
            pix[p] = ramp ? DW'(p) : DW'($urandom_range(65535));
            src_q.push_back(pix[p]);
        end
        for (int i = 0; i < OH; i++) begin
            for (int j = 0; j < OWD; j++) begin
                if (i * OWD + j < limit) begin
                    s = 0;
                    for (int di = 0; di < K; di++)
                        for (int dj = 0; dj < K; dj++)
                            s += int'($signed(pix[(i + di) * IMG_W + j + dj]));
                    exp_q.push_back(RW'(s));
                end
            end
        end
    endtask

    // ---------------- source driver, core model, monitor ----------------
    initial begin : drive_loop
        bit xfer;
        int r, c, s;
        clear_counters();
        forever begin
            @(negedge clk);
            cyc++;
            xfer = src_valid && src_ready;
            if (xfer) n_xfer++;
            if (resetn) begin
                if (busy) busy_seen++;
                if (start) start_cyc = cyc;
                if (done) begin
                    n_done++;
                    done_cyc = cyc;
                    if (n_clr > 0) check("frame_len_at_done", rd_since_clr, NPIX);
                end
                if (core_clr) begin
                    if (n_clr > 0) check("frame_len", rd_since_clr, NPIX);
                    n_clr++;
                    rd_since_clr = 0;
                    clr_idx_q.push_back(int'(img_idx));
                    pcnt = 0;
                    core_emit = 0;
                end
                if (core_rdata_r) begin
                    n_rd++;
                    rd_since_clr++;
                    last_rd_cyc = cyc;
                    if (pcnt < NPIX) begin
                        pbuf[pcnt] = core_data_in;
                        r = pcnt / IMG_W;
                        c = pcnt % IMG_W;
                        if (r >= K - 1 && c >= K - 1 && core_emit < core_limit) begin
                            s = 0;
                            for (int di = 0; di < K; di++)
                                for (int dj = 0; dj < K; dj++)
                                    s += int'($signed(pbuf[(r - K + 1 + di) * IMG_W + c - K + 1 + dj]));
                            pend = 1'b1;
                            pend_val = RW'(s);
                            core_emit++;
                            if (core_emit == NOUT && emit_extra) extra_pend = 1'b1;
                        end
                        pcnt++;
                    end
                end
                if (snk_valid) begin
                    n_snk++;
                    if (snk_last) n_last++;
                    if (n_snk == 1) first_snk = snk_data;
                    if (exp_q.size() == 0) begin
                        check("snk_unexpected", 1, 0);
                    end else begin
                        check("snk_data", snk_data, exp_q.pop_front());
                        check("snk_last", snk_last, (sb_idx % NOUT) == NOUT - 1);
                    end
                    sb_idx++;
                end
            end
            @(posedge clk);
            #1;
            if (xfer && src_q.size() > 0) void'(src_q.pop_front());
            if (pend) begin
                core_wdata_r = 1'b1; core_data_out = pend_val; pend = 1'b0;
            end else if (extra_pend || force_wd) begin
                core_wdata_r = 1'b1; core_data_out = 32'hDEAD_BEEF;
                extra_pend = 1'b0; force_wd = 1'b0;
            end else begin
                core_wdata_r = 1'b0;
            end
            if (src_q.size() > 0 && int'($urandom_range(99)) < valid_pct) begin
                src_valid = 1'b1; src_data = src_q[0];
            end else begin
                src_valid = 1'b0;
            end
        end
    end

    // ---------------- main sequence ----------------
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic do_start(input int n);
        start = 1'b1;
        num_img = 8'(n);
        tick();
        start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        int k = 0;
        while (n_done == 0 && k < budget) begin
            tick();
            k++;
        end
        check(tag, n_done > 0, 1);
    endtask

    task automatic check_all_zero(input string pfx);
        check({pfx, "_src_ready"}, src_ready, 0);
        check({pfx, "_core_data_in"}, core_data_in, 0);
        check({pfx, "_core_rdata_r"}, core_rdata_r, 0);
        check({pfx, "_core_clr"}, core_clr, 0);
        check({pfx, "_snk_valid"}, snk_valid, 0);
        check({pfx, "_snk_data"}, snk_data, 0);
        check({pfx, "_snk_last"}, snk_last, 0);
        check({pfx, "_img_idx"}, img_idx, 0);
        check({pfx, "_busy"}, busy, 0);
        check({pfx, "_done"}, done, 0);
        check({pfx, "_err_timeout"}, err_timeout, 0);
        check({pfx, "_err_extra"}, err_extra, 0);
    endtask

    initial begin : main_seq
        int k;
        repeat (3) tick();
        check_all_zero("reset");
        resetn = 1'b1;
        repeat (2) tick();

        // single ramp image, source always valid
        clear_counters();
        valid_pct = 100;
        load_image(1'b1, NOUT);
        do_start(1);
        wait_done("basic_done", 4000);
        repeat (3) tick();
        check("basic_rd_pulses", n_rd, NPIX);
        check("basic_results", n_snk, NOUT);
        check("basic_last_count", n_last, 1);
        check("basic_first_result", first_snk, 261);
        check("basic_done_count", n_done, 1);
        check("basic_busy_after", busy, 0);
        check("basic_clr_count", n_clr, 1);
        check("basic_exp_left", exp_q.size(), 0);

        // empty batch
        clear_counters();
        do_start(0);
        repeat (4) tick();
        check("zero_done_latency", done_cyc - start_cyc, 1);
        check("zero_done_count", n_done, 1);
        check("zero_busy_seen", busy_seen, 0);
        check("zero_clr_count", n_clr, 0);

        // batch of three random images with a stalling source
        clear_counters();
        valid_pct = 50;
        repeat (3) load_image(1'b0, NOUT);
        do_start(3);
        wait_done("batch_done", 20000);
        repeat (3) tick();
        check("batch_clr_count", n_clr, 3);
        check("batch_clr_idx_len", clr_idx_q.size(), 3);
        for (int i = 0; i < clr_idx_q.size(); i++) check("batch_clr_idx", clr_idx_q[i], i);
        check("batch_rd_pulses", n_rd, 3 * NPIX);
        check("batch_results", n_snk, 3 * NOUT);
        check("batch_last_count", n_last, 3);
        check("batch_img_idx_final", img_idx, 2);
        check("batch_done_count", n_done, 1);
        check("batch_exp_left", exp_q.size(), 0);

        // core stalls after 600 results -> drain timeout
        clear_counters();
        valid_pct = 100;
        core_limit = 600;
        load_image(1'b0, 600);
        do_start(1);
        wait_done("tmo_done", 4000);
        tick();
        check("tmo_err_timeout", err_timeout, 1);
        check("tmo_done_gap", done_cyc - last_rd_cyc, TIMEOUT);
        check("tmo_state_idle", dbg_state, 0);
        check("tmo_busy", busy, 0);
        check("tmo_results", n_snk, 600);
        check("tmo_err_extra", err_extra, 0);
        core_limit = NOUT;
        do_start(0);
        tick();
        check("tmo_cleared_by_start", err_timeout, 0);

        // 677th result and a spurious result in IDLE
        clear_counters();
        emit_extra = 1'b1;
        load_image(1'b0, NOUT);
        do_start(1);
        wait_done("extra_done", 4000);
        repeat (3) tick();
        emit_extra = 1'b0;
        check("extra_err_after_677", err_extra, 1);
        check("extra_results", n_snk, NOUT);
        do_start(0);
        tick();
        check("extra_cleared_by_start", err_extra, 0);
        force_wd = 1'b1;
        repeat (3) tick();
        check("extra_err_idle", err_extra, 1);
        check("extra_results_idle", n_snk, NOUT);

        // reset in the middle of LOAD
        clear_counters();
        load_image(1'b0, NOUT);
        do_start(2);
        k = 0;
        while (n_xfer < 400 && k < 3000) begin
            tick();
            k++;
        end
        check("midrst_reached_400", n_xfer >= 400, 1);
        check("midrst_busy_before", busy, 1);
        resetn = 1'b0;
        #1;
        check_all_zero("midrst");
        src_q.delete();
        exp_q.delete();
        pend = 1'b0;
        extra_pend = 1'b0;
        pcnt = 0;
        src_valid = 1'b0;
        repeat (2) tick();
        resetn = 1'b1;
        tick();
        clear_counters();
        load_image(1'b0, NOUT);
        do_start(1);
        wait_done("midrst_done", 4000);
        repeat (3) tick();
        check("midrst_clr_count", n_clr, 1);
        check("midrst_clr_idx_len", clr_idx_q.size(), 1);
        for (int i = 0; i < clr_idx_q.size(); i++) check("midrst_clr_idx", clr_idx_q[i], 0);
        check("midrst_rd_pulses", n_rd, NPIX);
        check("midrst_results", n_snk, NOUT);
        check("midrst_exp_left", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
